// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 host controller.
// DHT11_AUTO_START_EN adds the default auto-start period constant.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_RESP = 3'd2,
        RESP_L    = 3'd3,
        RESP_H    = 3'd4,
        BIT_L     = 3'd5,
        BIT_H     = 3'd6,
        CHECK     = 3'd7
    } dht_state_t;

    localparam int DHT_BITS = 40;

    localparam int DEF_CLK_FREQ_HZ   = 100_000_000;
    localparam int DEF_START_LOW_US  = 19_000;
    localparam int DEF_BIT_THRESH_US = 40;
    localparam int DEF_TIMEOUT_US    = 200;
`ifdef DHT11_AUTO_START_EN
    localparam int DEF_AUTO_PERIOD_US = 2_000_000;
`endif

    // MSB positions of each byte field within dht_data
    localparam int HUM_INT_MSB  = 31;
    localparam int HUM_DEC_MSB  = 23;
    localparam int TEMP_INT_MSB = 15;
    localparam int TEMP_DEC_MSB = 7;

endpackage

// File: rtl/dht11_controller_tick_gen_us.sv
// Free-running 1 us tick: one-cycle pulse every CLK_FREQ_HZ/1e6 clocks.
module tick_gen_us
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (o_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/dht11_controller.sv
// DHT11 single-wire host: wake pulse, response/bit timing, checksum check.
// Optional macro DHT11_AUTO_START_EN enables periodic internal start requests.
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
    parameter int START_LOW_US  = DEF_START_LOW_US,
    parameter int BIT_THRESH_US = DEF_BIT_THRESH_US,
    parameter int TIMEOUT_US    = DEF_TIMEOUT_US
`ifdef DHT11_AUTO_START_EN
    , parameter int AUTO_PERIOD_US = DEF_AUTO_PERIOD_US
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    inout  wire         dht_io,
    output logic [31:0] dht_data,
    output logic        valid,
    output logic        busy,
    output logic        error,
    output logic [3:0]  state_dbg
);

    localparam int TMR_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int TMR_W   = $clog2(TMR_MAX + 2);

    dht_state_t            r_state, w_state_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [5:0]            r_bit_cnt;
    logic [DHT_BITS-1:0]   r_shreg;
    logic [31:0]           r_data;
    logic                  r_valid, r_error, r_drive_low;
    logic                  r_sync1, r_sync2, r_sync3;

    logic                  w_tick, w_rise, w_fall, w_start_req, w_accept;
    logic                  w_shift, w_load, w_err_set, w_bit, w_sensor_phase;
    logic [TMR_W-1:0]      w_tmr_lim, w_width;
    logic [31:0]           w_frame;
    logic [7:0]            w_sum;

    tick_gen_us #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign dht_io    = r_drive_low ? 1'b0 : 1'bz;
    assign dht_data  = r_data;
    assign valid     = r_valid;
    assign error     = r_error;
    assign busy      = (r_state != IDLE);
    assign state_dbg = {1'b0, r_state};

    assign w_rise = r_sync2 & ~r_sync3;
    assign w_fall = ~r_sync2 & r_sync3;

    // Width includes the tick landing on the decode edge so N us of high reads as exactly N
    assign w_width   = r_timer + {{(TMR_W-1){1'b0}}, w_tick};
    assign w_bit     = (w_width >= TMR_W'(BIT_THRESH_US));
    assign w_tmr_lim = (r_state == START) ? TMR_W'(START_LOW_US) : TMR_W'(TIMEOUT_US);

    assign w_frame = r_shreg[DHT_BITS-1:8];
    assign w_sum   = w_frame[HUM_INT_MSB -: 8] + w_frame[HUM_DEC_MSB -: 8]
                   + w_frame[TEMP_INT_MSB -: 8] + w_frame[TEMP_DEC_MSB -: 8];

    assign w_sensor_phase = (r_state == WAIT_RESP) || (r_state == RESP_L) ||
                            (r_state == RESP_H) || (r_state == BIT_L) || (r_state == BIT_H);

`ifdef DHT11_AUTO_START_EN
    logic [31:0] r_auto_cnt;
    logic        w_auto_start;

    assign w_auto_start = (r_state == IDLE) && w_tick && (r_auto_cnt == 32'(AUTO_PERIOD_US - 1));
    assign w_start_req  = start | w_auto_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              r_auto_cnt <= '0;
        else if (w_accept)                      r_auto_cnt <= '0;
        else if (r_state == IDLE && w_tick)     r_auto_cnt <= r_auto_cnt + 1'b1;
    end
`else
    assign w_start_req = start;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE:      if (w_start_req) begin
                           w_state_nxt = START;
                           w_accept    = 1'b1;
                       end
            START:     if (r_timer == TMR_W'(START_LOW_US)) w_state_nxt = WAIT_RESP;
            WAIT_RESP: if (w_fall) w_state_nxt = RESP_L;
            RESP_L:    if (w_rise) w_state_nxt = RESP_H;
            RESP_H:    if (w_fall) w_state_nxt = BIT_L;
            BIT_L:     if (w_rise) w_state_nxt = BIT_H;
            BIT_H:     if (w_fall) begin
                           w_shift     = 1'b1;
                           w_state_nxt = (r_bit_cnt == 6'(DHT_BITS - 1)) ? CHECK : BIT_L;
                       end
            CHECK:     begin
                           if (w_sum == r_shreg[7:0]) w_load    = 1'b1;
                           else                       w_err_set = 1'b1;
                           w_state_nxt = IDLE;
                       end
            default:   w_state_nxt = IDLE;
        endcase
        // Timeout overrides any edge seen in the same cycle
        if (w_sensor_phase && r_timer == TMR_W'(TIMEOUT_US)) begin
            w_state_nxt = IDLE;
            w_shift     = 1'b0;
            w_err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync3     <= 1'b1;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
            r_drive_low <= 1'b0;
        end else begin
            r_sync1     <= dht_io;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_drive_low <= (w_state_nxt == START);
            r_valid     <= w_load;

            if (w_state_nxt != r_state)            r_timer <= '0;
            else if (w_tick && r_timer < w_tmr_lim) r_timer <= r_timer + 1'b1;

            if (r_state == RESP_H && w_state_nxt == BIT_L) r_bit_cnt <= '0;
            else if (w_shift)                              r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift) r_shreg <= {r_shreg[DHT_BITS-2:0], w_bit};
            if (w_load)  r_data  <= w_frame;

            if (w_accept)       r_error <= 1'b0;
            else if (w_err_set) r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dht11_controller.sv
// Directed bench for dht11_controller with a cycle-exact DHT11 sensor model.
// With DHT11_AUTO_START_EN defined it exercises only the auto-start path.
`timescale 1ns/1ps
module tb_dht11_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        sens_low = 1'b0;
    wire         dht_io;
    logic [31:0] dht_data;
    logic        valid, busy, error;
    logic [3:0]  state_dbg;

    int n_chk = 0;
    int n_pass = 0;
    int n_vld = 0;

    always #5 clk = ~clk;

    pullup (dht_io);
    assign dht_io = sens_low ? 1'b0 : 1'bz;

    dht11_controller #(
        .CLK_FREQ_HZ   (2_000_000),
        .START_LOW_US  (50),
        .BIT_THRESH_US (40),
        .TIMEOUT_US    (200)
`ifdef DHT11_AUTO_START_EN
        , .AUTO_PERIOD_US (500)
`endif
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dht_io    (dht_io),
        .dht_data  (dht_data),
        .valid     (valid),
        .busy      (busy),
        .error     (error),
        .state_dbg (state_dbg)
    );

    always @(negedge clk) if (valid) n_vld <= n_vld + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Two clocks per us in this bench; always returns 1 ns after a rising edge
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int max_cyc, input string tag);
        int n = 0;
        while (state_dbg != s && n < max_cyc) begin
            wait_cyc(1);
            n++;
        end
        check_eq(tag, {28'd0, state_dbg}, {28'd0, s});
    endtask

    task automatic do_start();
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        check_eq("start_state", {28'd0, state_dbg}, 32'd1);
        check_eq("start_drive_low", {31'd0, dht_io}, 32'd0);
        check_eq("start_err_clr", {31'd0, error}, 32'd0);
    endtask

    task automatic run_frame(input logic [39:0] f, input int w0, input int w1,
                             input int pulse_bit, input int abort_bit);
        int w;
        do_start();
        wait_state(4'd2, 400, "reach_wait_resp");
        wait_cyc(40);
        sens_low = 1'b1; wait_cyc(160);
        sens_low = 1'b0; wait_cyc(160);
        for (int i = 0; i < 40; i++) begin
            sens_low = 1'b1; wait_cyc(100);
            sens_low = 1'b0;
            w = f[39-i] ? w1 : w0;
            if (i == abort_bit) begin
                wait_cyc(10);
                reset = 1'b1;
                #1;
                check_eq("rst_data", dht_data, 32'd0);
                check_eq("rst_valid", {31'd0, valid}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_error", {31'd0, error}, 32'd0);
                check_eq("rst_state", {28'd0, state_dbg}, 32'd0);
                check_eq("rst_line", {31'd0, dht_io}, 32'd1);
                wait_cyc(3);
                reset = 1'b0;
                wait_cyc(4);
                return;
            end
            if (i == pulse_bit) begin
                wait_cyc(20);
                check_eq("pulse_in_bit_h", {28'd0, state_dbg}, 32'd6);
                start = 1'b1; wait_cyc(1);
                start = 1'b0; wait_cyc(2*w - 21);
            end else begin
                wait_cyc(2*w);
            end
        end
        sens_low = 1'b1; wait_cyc(100);
        sens_low = 1'b0; wait_cyc(20);
    endtask

    initial begin
        int v0;
        int n;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(2);

`ifdef DHT11_AUTO_START_EN
        n = 0;
        while (!busy && n < 1200) begin wait_cyc(1); n++; end
        check_eq("auto_first", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 1000) begin wait_cyc(1); n++; end
        check_eq("auto_first_end", {31'd0, busy}, 32'd0);
        check_eq("auto_first_err", {31'd0, error}, 32'd1);
        n = 0;
        while (!busy && n < 1200) begin wait_cyc(1); n++; end
        check_eq("auto_second", {31'd0, busy}, 32'd1);
        check_eq("auto_second_state", {28'd0, state_dbg}, 32'd1);
`else
        check_eq("reset_data", dht_data, 32'd0);
        check_eq("reset_valid", {31'd0, valid}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_error", {31'd0, error}, 32'd0);
        check_eq("reset_state", {28'd0, state_dbg}, 32'd0);
        check_eq("reset_line", {31'd0, dht_io}, 32'd1);

        // Good frame with a start pulse injected during bit 10 high phase
        v0 = n_vld;
        run_frame(40'h2D_00_17_05_49, 27, 70, 10, -1);
        check_eq("good_vld_cnt", n_vld - v0, 32'd1);
        check_eq("good_data", dht_data, 32'h2D001705);
        check_eq("good_error", {31'd0, error}, 32'd0);
        check_eq("good_not_queued", {31'd0, busy}, 32'd0);

        // Checksum mismatch keeps the previous reading
        v0 = n_vld;
        run_frame(40'h2D_00_17_05_48, 27, 70, -1, -1);
        check_eq("badsum_vld_cnt", n_vld - v0, 32'd0);
        check_eq("badsum_error", {31'd0, error}, 32'd1);
        check_eq("badsum_data", dht_data, 32'h2D001705);

        // Silent sensor: error after START_LOW_US + TIMEOUT_US = 250 us = 500 cycles
        do_start();
        n = 0;
        while (!error && n < 1000) begin wait_cyc(1); n++; end
        check_eq("timeout_cycles", (n >= 497 && n <= 503) ? 32'd500 : n, 32'd500);
        check_eq("timeout_busy", {31'd0, busy}, 32'd0);
        check_eq("timeout_line", {31'd0, dht_io}, 32'd1);
        check_eq("timeout_data", dht_data, 32'h2D001705);

        // 39 us highs decode as 0, 40 us highs as 1
        v0 = n_vld;
        run_frame(40'hA5_5A_01_02_02, 39, 40, -1, -1);
        check_eq("thresh_vld_cnt", n_vld - v0, 32'd1);
        check_eq("thresh_data", dht_data, 32'hA55A0102);
        check_eq("thresh_error", {31'd0, error}, 32'd0);

        // Reset in the middle of bit 20, then a fresh conversion
        run_frame(40'h2D_00_17_05_49, 27, 70, -1, 20);
        v0 = n_vld;
        run_frame(40'h2D_00_17_05_49, 27, 70, -1, -1);
        check_eq("post_rst_vld_cnt", n_vld - v0, 32'd1);
        check_eq("post_rst_data", dht_data, 32'h2D001705);
        check_eq("post_rst_error", {31'd0, error}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dht11_controller.md
Name: dht11_controller

Overview:
- Host-side initiator for the DHT11 single-wire humidity/temperature sensor.
- On a start request it drives the wake pulse, then times the sensor's response and 40 data bits, and verifies the checksum.
- Publishes a 32-bit word {hum_int, hum_dec, temp_int, temp_dec}, 8 bits each, MSB first. This is the exact layout consumed by the display controller's dht11 input.
- Sits between the board pin (external pull-up) and the display/UART consumers.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency; used to derive the internal 1 us tick.
- START_LOW_US, 19_000, duration the host holds the line low for the wake pulse.
- BIT_THRESH_US, 40, high-phase width threshold: width >= threshold decodes as 1, width < threshold decodes as 0.
- TIMEOUT_US, 200, maximum dwell in any sensor-driven phase before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  single-cycle request; ignored while busy
- dht_io  inout  1  sensor line; drives 0 or high-Z only, never drives 1
- dht_data  out  32  last good reading {hum_int, hum_dec, temp_int, temp_dec}
- valid  out  1  one-cycle pulse when dht_data updates
- busy  out  1  high in every state except IDLE
- error  out  1  level; set on timeout or checksum mismatch; cleared when the next start is accepted
- state_dbg  out  4  current FSM state encoding

Behaviour:
- Reset values: dht_data=0, valid=0, busy=0, error=0, dht_io released (Z), state=IDLE, all counters 0.
- Input path: dht_io passes through a 2-FF synchronizer. Rising and falling edges are detected on the synchronized value, so decode latency is 2 cycles.
- A 1 us tick pulses one cycle every CLK_FREQ_HZ/1_000_000 clocks. All phase timers count ticks and restart at 0 on every state entry.
- FSM states and transitions:
  - IDLE: on start, go to START and clear error.
  - START: drive dht_io low. After START_LOW_US ticks, release and go to WAIT_RESP.
  - WAIT_RESP: on a falling edge, go to RESP_L.
  - RESP_L: on a rising edge, go to RESP_H.
  - RESP_H: on a falling edge, go to BIT_L and set bit_cnt=0.
  - BIT_L: on a rising edge, go to BIT_H.
  - BIT_H: on a falling edge, shift (width >= BIT_THRESH_US) into a 40-bit shift register MSB first and increment bit_cnt. If bit_cnt reaches 40, go to CHECK; otherwise go to BIT_L.
  - CHECK: one cycle. If the sum of bytes [39:32],[31:24],[23:16],[15:8] mod 256 equals byte [7:0], load dht_data = shreg[39:8] and pulse valid. Otherwise set error. Then go to IDLE.
- Timeout: in WAIT_RESP, RESP_L, RESP_H, BIT_L or BIT_H, if the timer reaches TIMEOUT_US, set error, release the line and go to IDLE. dht_data is kept unchanged.
- Error path: dht_data never changes on an error.
- The trailing 50 us sensor low after bit 40 needs no handling; the line returns high by pull-up while the FSM is in IDLE.
- start while busy: ignored, not queued.
- Simultaneous start and timeout in the same cycle: the timeout wins. The FSM returns to IDLE, and start is honored only if it is reasserted later.
- Reset mid-operation: immediately release the line and return every register to its reset value. This includes dht_data clearing to 0.
- Width counters saturate at TIMEOUT_US, so they never wrap.

Optional Feature:
- Macro DHT11_AUTO_START_EN.
- Defined: an internal counter issues an internal start every 2_000_000 us ticks while in IDLE, OR-ed with the start port. The counter resets to 0 on every accepted start, whichever source issued it.
- Undefined: conversions start only from the start port; the auto counter logic is absent.

Decomposition:
- Package dht11_pkg holds:
  - the state enum: IDLE, START, WAIT_RESP, RESP_L, RESP_H, BIT_L, BIT_H, CHECK;
  - DHT_BITS=40;
  - the default timing constants;
  - the byte-field index constants for dht_data.
- One sub-module, tick_gen_us: parameter CLK_FREQ_HZ, input clk and reset, output a 1-cycle tick.

Test Plan (sim with START_LOW_US=50):
- Sensor model sends 0x2D,0x00,0x17,0x05, checksum 0x49, with 0-bits high for 27 us and 1-bits high for 70 us -> valid pulses once, dht_data=0x2D001705, error=0.
- Same bytes but checksum 0x48 -> error=1, no valid pulse, dht_data keeps its previous value.
- No sensor response, line stays high after release -> error=1 at START_LOW_US+TIMEOUT_US (±3 cycles), busy falls, dht_io is Z.
- Threshold bits: high widths of 39 us and 40 us -> decoded as 0 and 1 respectively.
- start pulsed during BIT_H -> ignored, frame completes normally. Reset asserted at bit 20 -> all outputs 0, dht_io Z, then a fresh start reads correctly.
- With DHT11_AUTO_START_EN defined and the period overridden to 500 ticks -> a second conversion begins automatically with no start-port activity.
